timer_compare_unit: RTL and testbench
=====================================

Name: timer_compare_unit

Overview:
Multi-channel output-compare unit for the Timer_1 peripheral. It contains a prescaled up-counter with a programmable period and N compare channels. Each channel drives a waveform output in one of several modes: toggle, set, clear, PWM or inverted PWM. It replaces the single edge-clocked toggle cell with a fully synchronous block that the bus register file programs directly.

Parameters:
CNT_W, 16, counter, period and compare width in bits
N_CH, 4, number of compare channels (1..8)
PRE_W, 8, prescaler reload width in bits

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_en  in  1  counter enable; low freezes prescaler, counter and outputs
i_prescale  in  PRE_W  tick every (i_prescale+1) clk cycles
i_period  in  CNT_W  counter counts 0..i_period inclusive
i_cmp  in  N_CH*CNT_W  compare value per channel; channel k occupies bits [k*CNT_W +: CNT_W]
i_mode  in  N_CH*3  mode per channel; channel k occupies bits [k*3 +: 3]
o_count  out  CNT_W  current counter value
o_ch  out  N_CH  channel waveform outputs, registered
o_match  out  N_CH  one-cycle compare-match pulses
o_overflow  out  1  one-cycle pulse on counter wrap

Behaviour:
- Reset (async, rst=1): prescaler=0, o_count=0, o_ch=0, o_match=0, o_overflow=0. Reset asserted mid-count clears all state immediately. The first tick after release occurs i_prescale+1 cycles later.
- Prescaler: pcnt increments each clk while i_en=1. When pcnt>=i_prescale, tick=1 and pcnt returns to 0. i_prescale=0 gives a tick every cycle.
- Counter on tick: if o_count>=i_period, o_count becomes 0 and o_overflow pulses on the same edge. Otherwise o_count increments. The >= comparison makes a period lowered below the current count wrap on the next tick. i_period=0 holds the count at 0 and pulses o_overflow every tick.
- Match: on a tick where the pre-update o_count==cmp[k], o_match[k] pulses for 1 cycle, registered on that edge. With no tick, o_match=0 and o_overflow=0.
- Modes, applied on the tick edge:
  - 0 off: o_ch[k] forced to 0 on every clk edge, regardless of tick or i_en.
  - 1 toggle: o_ch[k] inverts on match.
  - 2 set: o_ch[k] goes to 1 on match.
  - 3 clear: o_ch[k] goes to 0 on match.
  - 4 PWM: o_ch[k] = (next_count < cmp[k]). cmp=0 gives constant 0; cmp>i_period gives constant 1; duty = cmp/(period+1).
  - 5 inverted PWM: complement of mode 4.
  - 6, 7 reserved: o_ch[k] holds.
- Match and overflow on the same tick: modes 1-3 act only on the match. Modes 4/5 use next_count=0.
- Mode change mid-run: the new mode takes effect on the next tick. The exception is mode 0, which takes effect on the next clk edge. The output register is not reset on a mode change, except by mode 0.
- i_en=0: everything holds. The only clocked update is the mode-0 force.
- Total: one clk of latency from tick to output. All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
TIMER_ONESHOT_EN.
- Defined: adds input i_oneshot (1 bit) and output o_done (1 bit, reset 0). If i_oneshot=1 at a wrap, the counter stops at 0 and o_done becomes 1. Match, overflow and output updates then stop. A 0->1 transition of i_en clears o_done and restarts counting. o_overflow still pulses on the stopping wrap.
- Undefined: neither port exists and the counter always free-runs.

Test Plan:
1. Reset/basic count: prescale=0, period=4, en=1 → o_count runs 0,1,2,3,4,0; o_overflow pulses on the 4→0 edge every 5 cycles. Assert rst mid-count → o_count=0 and all outputs 0 immediately.
2. Prescaler: prescale=2, period=3 → o_count advances every 3 clk; overflow every 12 clk.
3. Toggle: ch0 mode 1, cmp=2, period=4, prescale=0 → o_match[0] pulses once per 5 cycles; o_ch[0] period is 10 cycles, 50% duty.
4. PWM edges: period=9, ch1 mode 4 with cmp=3 → high 3 of 10 ticks; cmp=0 → always 0; cmp=12 → always 1. Mode 5 with cmp=3 → high 7 of 10.
5. Set/clear/off with simultaneous events: ch2 mode 2, cmp=0 and ch3 mode 3, cmp=period → ch2 set at count 0 and ch3 cleared at wrap. Switching ch2 to mode 0 → ch2=0 on the next clk even with en=0.
6. Period shrink: count=7, period rewritten to 3 → next tick wraps to 0 with an overflow pulse. With TIMER_ONESHOT_EN and i_oneshot=1 → stops at 0, o_done=1; an en 0→1 transition restarts and clears o_done.

Source files
------------

// File: rtl/timer_compare_unit.sv
// timer_compare_unit: prescaled up-counter with N output-compare channels; optional one-shot stop via TIMER_ONESHOT_EN
module timer_compare_unit #(
    parameter int CNT_W = 16,
    parameter int N_CH  = 4,
    parameter int PRE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [PRE_W-1:0]      i_prescale,
    input  logic [CNT_W-1:0]      i_period,
    input  logic [N_CH*CNT_W-1:0] i_cmp,
    input  logic [N_CH*3-1:0]     i_mode,
    output logic [CNT_W-1:0]      o_count,
    output logic [N_CH-1:0]       o_ch,
    output logic [N_CH-1:0]       o_match,
    output logic                  o_overflow
`ifdef TIMER_ONESHOT_EN
    ,
    input  logic                  i_oneshot,
    output logic                  o_done
`endif
);
    logic [PRE_W-1:0] pcnt;
    logic             stopped;
    logic             tick;
    logic             wrap;
    logic [CNT_W-1:0] next_count;
    logic [N_CH-1:0]  hit;
    logic [N_CH-1:0]  ch_nxt;

`ifdef TIMER_ONESHOT_EN
    logic en_q;
    assign stopped = o_done;
    // one-shot latch: set on a wrap with i_oneshot, cleared by a rising i_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            o_done <= 1'b0;
        end else begin
            en_q <= i_en;
            if (i_en && !en_q)
                o_done <= 1'b0;
            else if (tick && wrap && i_oneshot)
                o_done <= 1'b1;
        end
    end
`else
    assign stopped = 1'b0;
`endif

    assign tick       = i_en && !stopped && (pcnt >= i_prescale);
    assign wrap       = o_count >= i_period;
    assign next_count = wrap ? '0 : o_count + 1'b1;

    // per-channel match detection and next waveform value
    always_comb begin
        hit    = '0;
        ch_nxt = '0;
        for (int k = 0; k < N_CH; k++) begin
            hit[k]    = o_count == i_cmp[k*CNT_W +: CNT_W];
            ch_nxt[k] = (i_mode[k*3 +: 3] == 3'd0) ? 1'b0 :
                        !tick                      ? o_ch[k] :
                        (i_mode[k*3 +: 3] == 3'd1) ? o_ch[k] ^ hit[k] :
                        (i_mode[k*3 +: 3] == 3'd2) ? o_ch[k] | hit[k] :
                        (i_mode[k*3 +: 3] == 3'd3) ? o_ch[k] & ~hit[k] :
                        (i_mode[k*3 +: 3] == 3'd4) ? (next_count < i_cmp[k*CNT_W +: CNT_W]) :
                        (i_mode[k*3 +: 3] == 3'd5) ? !(next_count < i_cmp[k*CNT_W +: CNT_W]) :
                        o_ch[k];
        end
    end

    // prescaler, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt       <= '0;
            o_count    <= '0;
            o_ch       <= '0;
            o_match    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (stopped)
                pcnt <= '0;
            else if (i_en)
                pcnt <= (pcnt >= i_prescale) ? '0 : pcnt + 1'b1;
            if (tick)
                o_count <= next_count;
            o_ch       <= ch_nxt;
            o_match    <= tick ? hit : '0;
            o_overflow <= tick && wrap;
        end
    end
endmodule

// File: tb/tb_timer_compare_unit.sv
// tb_timer_compare_unit: directed checks of counting, prescaling, compare modes and period shrink
module tb_timer_compare_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  prescale;
    logic [15:0] period;
    logic [63:0] cmp;
    logic [11:0] mode;
    logic [15:0] o_count;
    logic [3:0]  o_ch;
    logic [3:0]  o_match;
    logic        o_overflow;
`ifdef TIMER_ONESHOT_EN
    logic        oneshot;
    logic        o_done;
`endif
    int checks = 0;
    int errors = 0;

    timer_compare_unit dut (
        .clk(clk),
        .rst(rst),
        .i_en(en),
        .i_prescale(prescale),
        .i_period(period),
        .i_cmp(cmp),
        .i_mode(mode),
        .o_count(o_count),
        .o_ch(o_ch),
        .o_match(o_match),
        .o_overflow(o_overflow)
`ifdef TIMER_ONESHOT_EN
        ,
        .i_oneshot(oneshot),
        .o_done(o_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [2:0] m, input logic [15:0] c);
        mode[k*3 +: 3]  = m;
        cmp[k*16 +: 16] = c;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int pw_mode [4] = '{4, 4, 4, 5};
    int pw_cmp  [4] = '{3, 0, 12, 3};
    int pw_duty [4] = '{3, 0, 10, 7};

    initial begin
        rst = 1'b1; en = 1'b0; prescale = 8'd0; period = 16'd4; cmp = '0; mode = '0;
`ifdef TIMER_ONESHOT_EN
        oneshot = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ch", 32'(o_ch), 32'd0);
        chk("rst_match", 32'(o_match), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        en = 1'b1;
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("t1_count", 32'(o_count), 32'(i % 5));
            chk("t1_ovf", 32'(o_overflow), 32'(i == 5));
            chk("t1_match", 32'(o_match), (i % 5 == 1) ? 32'hF : 32'h0);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_count", 32'(o_count), 32'd0);
        chk("midrst_ch", 32'(o_ch), 32'd0);
        chk("midrst_match", 32'(o_match), 32'd0);
        chk("midrst_ovf", 32'(o_overflow), 32'd0);
        prescale = 8'd2;
        period = 16'd3;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            chk("t2_count", 32'(o_count), 32'((i / 3) % 4));
            chk("t2_ovf", 32'(o_overflow), 32'(i % 12 == 0));
        end
        prescale = 8'd0;
        period = 16'd4;
        set_ch(0, 3'd1, 16'd2);
        set_ch(1, 3'd0, 16'd7);
        set_ch(2, 3'd0, 16'd7);
        set_ch(3, 3'd0, 16'd7);
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("t3_ch", 32'(o_ch), 32'(((i + 2) / 5) % 2));
            chk("t3_match0", 32'(o_match[0]), 32'((i - 1) % 5 == 2));
        end
        period = 16'd9;
        set_ch(0, 3'd0, 16'd7);
        for (int c = 0; c < 4; c++) begin
            int hi;
            hi = 0;
            set_ch(1, 3'(pw_mode[c]), 16'(pw_cmp[c]));
            do_reset();
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                chk("t4_pwm", 32'(o_ch[1]), 32'(((i % 10) < pw_cmp[c]) ^ (pw_mode[c] == 5)));
                hi += int'(o_ch[1]);
            end
            chk("t4_duty", 32'(hi), 32'(pw_duty[c]));
        end
        period = 16'd4;
        set_ch(1, 3'd0, 16'd7);
        set_ch(2, 3'd2, 16'd0);
        set_ch(3, 3'd2, 16'd1);
        do_reset();
        @(negedge clk);
        chk("t5_set_ch", 32'(o_ch), 32'b0100);
        chk("t5_set_match", 32'(o_match), 32'b0100);
        @(negedge clk);
        chk("t5_pre_ch", 32'(o_ch), 32'b1100);
        chk("t5_pre_match", 32'(o_match), 32'b1000);
        set_ch(3, 3'd3, 16'd4);
        repeat (2) @(negedge clk);
        chk("t5_hold_ch", 32'(o_ch), 32'b1100);
        chk("t5_hold_count", 32'(o_count), 32'd4);
        @(negedge clk);
        chk("t5_clr_ch", 32'(o_ch), 32'b0100);
        chk("t5_clr_ovf", 32'(o_overflow), 32'd1);
        chk("t5_clr_match", 32'(o_match), 32'b1000);
        chk("t5_clr_count", 32'(o_count), 32'd0);
        @(negedge clk);
        chk("t5_reset_ch", 32'(o_ch), 32'b0100);
        chk("t5_reset_match", 32'(o_match), 32'b0100);
        en = 1'b0;
        set_ch(2, 3'd0, 16'd0);
        @(negedge clk);
        chk("t5_off_ch", 32'(o_ch), 32'd0);
        chk("t5_off_count", 32'(o_count), 32'd1);
        chk("t5_off_match", 32'(o_match), 32'd0);
        en = 1'b1;
        set_ch(3, 3'd0, 16'd7);
        period = 16'd9;
        do_reset();
        repeat (7) @(negedge clk);
        chk("t6_count7", 32'(o_count), 32'd7);
        period = 16'd3;
        @(negedge clk);
        chk("t6_wrap_count", 32'(o_count), 32'd0);
        chk("t6_wrap_ovf", 32'(o_overflow), 32'd1);
        @(negedge clk);
        chk("t6_after_count", 32'(o_count), 32'd1);
        chk("t6_after_ovf", 32'(o_overflow), 32'd0);
`ifdef TIMER_ONESHOT_EN
        oneshot = 1'b1;
        do_reset();
        repeat (4) @(negedge clk);
        chk("os_stop_count", 32'(o_count), 32'd0);
        chk("os_stop_ovf", 32'(o_overflow), 32'd1);
        chk("os_stop_done", 32'(o_done), 32'd1);
        @(negedge clk);
        chk("os_held_count", 32'(o_count), 32'd0);
        chk("os_held_ovf", 32'(o_overflow), 32'd0);
        chk("os_held_done", 32'(o_done), 32'd1);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("os_restart_done", 32'(o_done), 32'd0);
        @(negedge clk);
        chk("os_restart_count", 32'(o_count), 32'd1);
        oneshot = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
